// File: rtl/m72_video_pkg.sv
// Shared definitions for the M72 tilemap fetch path.
// Contents: fetch FSM state enum, VRAM code/attribute word bit positions,
// tile geometry, and the per-group attribute payload passed to the shadow stage.
package m72_video_pkg;

   localparam int unsigned TILE_W    = 8;
   localparam int unsigned MAP_COLS  = 64;
   localparam int unsigned COL_W     = $clog2(MAP_COLS);
   localparam int unsigned VRAM_DW   = 16;

   // Code word fields
   localparam int unsigned IDX_MSB   = 11;
   localparam int unsigned FLIPX_BIT = 14;
   localparam int unsigned FLIPY_BIT = 15;

   // Attribute word fields
   localparam int unsigned COLOR_MSB = 3;
   localparam int unsigned PRIO_BIT  = 7;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_REQ_CODE = 2'd1,
      ST_REQ_ATTR = 2'd2,
      ST_DONE     = 2'd3
   } fetch_state_e;

   // Per-group attributes that switch on the shifter load pulse
   typedef struct packed {
      logic       flip_x;
      logic [3:0] color;
      logic       prio;
   } tile_attr_t;

endpackage

// File: rtl/m72_tile_fetch_if.sv
// VRAM read port used by the tile fetch sequencer.
// master: vram_addr/vram_rd out, vram_ack/vram_data in (fetcher side)
// slave : the VRAM arbiter side
interface m72_tile_fetch_if
   import m72_video_pkg::*;
#(
   parameter int unsigned AW = 13
) ();
   logic [AW-1:0]      vram_addr;
   logic               vram_rd;
   logic               vram_ack;
   logic [VRAM_DW-1:0] vram_data;

   modport master (output vram_addr, output vram_rd, input vram_ack, input vram_data);
   modport slave  (input vram_addr, input vram_rd, output vram_ack, output vram_data);
endinterface

// File: rtl/m72_tile_shadow.sv
// Shadow/promote register pair for the per-group tile attributes.
// Ports: clock/reset; capture loads nxt_attr into the shadow; promote moves
// the shadow to cur_attr and clears blank; underrun sets blank and keeps cur_attr.
module m72_tile_shadow
   import m72_video_pkg::*;
(
   input  logic       clock,
   input  logic       reset,
   input  logic       capture,
   input  tile_attr_t nxt_attr,
   input  logic       promote,
   input  logic       underrun,
   output tile_attr_t cur_attr,
   output logic       blank
);

   tile_attr_t shadow_q, shadow_d;
   tile_attr_t cur_q, cur_d;
   logic       blank_q, blank_d;

   // Capture and promote are mutually exclusive (REQ_ATTR vs DONE)
   always_comb begin
      shadow_d = shadow_q;
      cur_d    = cur_q;
      blank_d  = blank_q;
      if (capture) shadow_d = nxt_attr;
      if (promote) begin
         cur_d   = shadow_q;
         blank_d = 1'b0;
      end else if (underrun) begin
         blank_d = 1'b1;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         shadow_q <= '0;
         cur_q    <= '0;
         blank_q  <= 1'b0;
      end else begin
         shadow_q <= shadow_d;
         cur_q    <= cur_d;
         blank_q  <= blank_d;
      end
   end

   assign cur_attr = cur_q;
   assign blank    = blank_q;

endmodule

// File: rtl/m72_tile_fetch.sv
// Per-layer tilemap fetch sequencer: reads code+attribute words for the next
// 8-pixel group, presents the tile-ROM address early and switches
// flip/colour/priority on the shifter load pulse.
// Ports: clock/reset, ce_pix, h/v counters, scroll_x/y, vram (VRAM read bus),
// tile_rom_addr, pixel_load_n (combinational load strobe), flip_x, color,
// prio, blank, underrun_cnt.
// Build option: M72_FETCH_UNDERRUN_CNT_EN enables the saturating underrun counter.
module m72_tile_fetch
   import m72_video_pkg::*;
#(
   parameter int unsigned ACTIVE_W = 384,
   parameter int unsigned VRAM_AW  = 13
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    ce_pix,
   input  logic [8:0]              h_count,
   input  logic [8:0]              v_count,
   input  logic [8:0]              scroll_x,
   input  logic [8:0]              scroll_y,
   m72_tile_fetch_if.master        vram,
   output logic [14:0]             tile_rom_addr,
   output logic                    pixel_load_n,
   output logic                    flip_x,
   output logic [3:0]              color,
   output logic                    prio,
   output logic                    blank,
   output logic [15:0]             underrun_cnt
);

   localparam logic [8:0] WIN_END = 9'(ACTIVE_W - TILE_W);

   fetch_state_e     state_q, state_d;
   logic             pend_q, pend_d;
   logic [COL_W-1:0] pend_col_q, pend_col_d, cur_col_q, cur_col_d;
   logic [8:0]       pend_y_q, pend_y_d, cur_y_q, cur_y_d;
   logic [IDX_MSB:0] idx_q, idx_d;
   logic             fx_q, fx_d, fy_q, fy_d;
   logic             discard_q, discard_d;
   logic [14:0]      tile_rom_addr_q, tile_rom_addr_d;

   logic             last_group, start, load, underrun, promote, leave_idle;
   logic             discard_now, req_ack, attr_ok;
   logic [COL_W-1:0] tgt_col;
   logic [8:0]       tgt_line, tgt_y;
   logic             rd_c, wsel_c;
   tile_attr_t       nxt_attr, cur_attr;
   logic             unused_ok;

   // Group timing and target tile of the group that follows
   assign last_group = (h_count[8:3] == 6'd63);
   assign start      = ce_pix && (h_count[2:0] == 3'd0) && ((h_count < WIN_END) || last_group);
   assign load       = ce_pix && (h_count[2:0] == 3'd7);
   assign tgt_col    = h_count[8:3] + 6'd1 + scroll_x[8:3];
   assign tgt_line   = last_group ? (v_count + 9'd1) : v_count;
   assign tgt_y      = tgt_line + scroll_y;

   // Underrun only counts when a fetch is owed: busy, or about to leave IDLE
   assign underrun    = load && (state_q != ST_DONE) && ((state_q != ST_IDLE) || pend_q);
   assign promote     = load && (state_q == ST_DONE);
   assign leave_idle  = (state_q == ST_IDLE) && pend_q;
   assign discard_now = discard_q || underrun;
   assign req_ack     = ((state_q == ST_REQ_CODE) || (state_q == ST_REQ_ATTR)) && vram.vram_ack;
   assign attr_ok     = (state_q == ST_REQ_ATTR) && vram.vram_ack && !discard_now;

   // FSM state register
   always_ff @(posedge clock or posedge reset) begin
      if (reset) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   // FSM next state; a discarded request returns to IDLE on its ack
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:     if (pend_q) state_d = ST_REQ_CODE;
         ST_REQ_CODE: if (vram.vram_ack) state_d = discard_now ? ST_IDLE : ST_REQ_ATTR;
         ST_REQ_ATTR: if (vram.vram_ack) state_d = discard_now ? ST_IDLE : ST_DONE;
         ST_DONE:     if (load) state_d = ST_IDLE;
         default:     state_d = ST_IDLE;
      endcase
   end

   // FSM outputs: read strobe and word select
   always_comb begin
      rd_c   = 1'b0;
      wsel_c = 1'b0;
      case (state_q)
         ST_REQ_CODE: rd_c = 1'b1;
         ST_REQ_ATTR: begin
            rd_c   = 1'b1;
            wsel_c = 1'b1;
         end
         default: ;
      endcase
   end

   // Datapath: pending target, in-flight target, code latch, ROM address
   always_comb begin
      pend_d          = start || (pend_q && !leave_idle);
      pend_col_d      = start ? tgt_col : pend_col_q;
      pend_y_d        = start ? tgt_y : pend_y_q;
      cur_col_d       = leave_idle ? pend_col_q : cur_col_q;
      cur_y_d         = leave_idle ? pend_y_q : cur_y_q;
      idx_d           = idx_q;
      fx_d            = fx_q;
      fy_d            = fy_q;
      tile_rom_addr_d = tile_rom_addr_q;
      discard_d       = req_ack ? 1'b0 : discard_now;
      if ((state_q == ST_REQ_CODE) && vram.vram_ack && !discard_now) begin
         idx_d = vram.vram_data[IDX_MSB:0];
         fx_d  = vram.vram_data[FLIPX_BIT];
         fy_d  = vram.vram_data[FLIPY_BIT];
      end
      if (attr_ok)
         tile_rom_addr_d = {idx_q, fy_q ? ~cur_y_q[2:0] : cur_y_q[2:0]};
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         pend_q          <= 1'b0;
         pend_col_q      <= '0;
         pend_y_q        <= '0;
         cur_col_q       <= '0;
         cur_y_q         <= '0;
         idx_q           <= '0;
         fx_q            <= 1'b0;
         fy_q            <= 1'b0;
         discard_q       <= 1'b0;
         tile_rom_addr_q <= '0;
      end else begin
         pend_q          <= pend_d;
         pend_col_q      <= pend_col_d;
         pend_y_q        <= pend_y_d;
         cur_col_q       <= cur_col_d;
         cur_y_q         <= cur_y_d;
         idx_q           <= idx_d;
         fx_q            <= fx_d;
         fy_q            <= fy_d;
         discard_q       <= discard_d;
         tile_rom_addr_q <= tile_rom_addr_d;
      end
   end

   assign nxt_attr = '{flip_x: fx_q,
                       color:  vram.vram_data[COLOR_MSB:0],
                       prio:   vram.vram_data[PRIO_BIT]};

   m72_tile_shadow u_shadow (
      .clock    (clock),
      .reset    (reset),
      .capture  (attr_ok),
      .nxt_attr (nxt_attr),
      .promote  (promote),
      .underrun (underrun),
      .cur_attr (cur_attr),
      .blank    (blank)
   );

`ifdef M72_FETCH_UNDERRUN_CNT_EN
   logic [15:0] urun_cnt_q, urun_cnt_d;

   // Saturating underrun counter
   always_comb begin
      urun_cnt_d = urun_cnt_q;
      if (underrun && (urun_cnt_q != 16'hFFFF)) urun_cnt_d = urun_cnt_q + 16'd1;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) urun_cnt_q <= '0;
      else       urun_cnt_q <= urun_cnt_d;
   end

   assign underrun_cnt = urun_cnt_q;
`else
   assign underrun_cnt = 16'h0000;
`endif

   assign vram.vram_addr = VRAM_AW'({cur_y_q[8:3], cur_col_q, wsel_c});
   assign vram.vram_rd   = rd_c;
   assign tile_rom_addr  = tile_rom_addr_q;
   assign pixel_load_n   = !load;
   assign flip_x         = cur_attr.flip_x;
   assign color          = cur_attr.color;
   assign prio           = cur_attr.prio;

   // Fine scroll and reserved code bits are consumed elsewhere
   assign unused_ok = &{1'b0, scroll_x[2:0], vram.vram_data[13:12]};

endmodule

// File: tb/tb_m72_tile_fetch.sv
// Directed bench for m72_tile_fetch with a small VRAM responder model.
module tb_m72_tile_fetch;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        ce_pix = 1'b0;
   logic [8:0]  h_count = '0;
   logic [8:0]  v_count = '0;
   logic [8:0]  scroll_x = '0;
   logic [8:0]  scroll_y = '0;
   logic [14:0] tile_rom_addr;
   logic        pixel_load_n;
   logic        flip_x;
   logic [3:0]  color;
   logic        prio;
   logic        blank;
   logic [15:0] underrun_cnt;

   int total = 0;
   int bad   = 0;

`ifdef M72_FETCH_UNDERRUN_CNT_EN
   localparam logic [15:0] URUN1 = 16'd1;
`else
   localparam logic [15:0] URUN1 = 16'd0;
`endif

   always #5 clock = ~clock;

   m72_tile_fetch_if #(.AW(13)) vram_if ();

   m72_tile_fetch #(.ACTIVE_W(384), .VRAM_AW(13)) dut (
      .clock         (clock),
      .reset         (reset),
      .ce_pix        (ce_pix),
      .h_count       (h_count),
      .v_count       (v_count),
      .scroll_x      (scroll_x),
      .scroll_y      (scroll_y),
      .vram          (vram_if),
      .tile_rom_addr (tile_rom_addr),
      .pixel_load_n  (pixel_load_n),
      .flip_x        (flip_x),
      .color         (color),
      .prio          (prio),
      .blank         (blank),
      .underrun_cnt  (underrun_cnt)
   );

   // VRAM responder: acks after ack_dly+1 cycles of vram_rd, unless blocked
   logic [15:0] mem [0:8191];
   logic        m_ack = 1'b0;
   logic        f_ack = 1'b0;
   logic        ack_block = 1'b0;
   logic [15:0] m_data = '0;
   int          wcnt = 0;
   int          ack_dly = 1;
   logic [12:0] last_code_addr = '1;
   logic [12:0] last_attr_addr = '1;

   assign vram_if.vram_ack  = m_ack | f_ack;
   assign vram_if.vram_data = m_data;

   always @(posedge clock) begin
      if (reset) begin
         m_ack <= 1'b0;
         wcnt  <= 0;
      end else if (vram_if.vram_rd && !m_ack && !ack_block) begin
         if (wcnt >= ack_dly) begin
            m_ack  <= 1'b1;
            m_data <= mem[vram_if.vram_addr];
            wcnt   <= 0;
            if (vram_if.vram_addr[0]) last_attr_addr <= vram_if.vram_addr;
            else                      last_code_addr <= vram_if.vram_addr;
         end else begin
            wcnt <= wcnt + 1;
         end
      end else begin
         m_ack <= 1'b0;
         if (!vram_if.vram_rd) wcnt <= 0;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // One pixel: ce_pix for one clock, then three idle clocks
   task automatic pix(input logic [8:0] h);
      h_count = h;
      ce_pix  = 1'b1;
      @(posedge clock); #1;
      ce_pix  = 1'b0;
      repeat (3) @(posedge clock);
      #1;
   endtask

   // Full 8-pixel group, checking the ROM address and load strobe before the load
   task automatic group(input string tag, input logic [8:0] base, input logic [14:0] exp_tile);
      for (int p = 0; p < 7; p++) pix(9'(base + 9'(p)));
      h_count = 9'(base + 9'd7);
      ce_pix  = 1'b1;
      #1;
      chk({tag, "_pld"},  32'(pixel_load_n), 32'd0);
      chk({tag, "_tile"}, 32'(tile_rom_addr), 32'(exp_tile));
      pix(9'(base + 9'd7));
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_rd"},    32'(vram_if.vram_rd), 32'd0);
      chk({tag, "_addr"},  32'(vram_if.vram_addr), 32'd0);
      chk({tag, "_tile"},  32'(tile_rom_addr), 32'd0);
      chk({tag, "_pld"},   32'(pixel_load_n), 32'd1);
      chk({tag, "_flip"},  32'(flip_x), 32'd0);
      chk({tag, "_color"}, 32'(color), 32'd0);
      chk({tag, "_prio"},  32'(prio), 32'd0);
      chk({tag, "_blank"}, 32'(blank), 32'd0);
      chk({tag, "_ucnt"},  32'(underrun_cnt), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < 8192; i++) mem[i] = 16'h0000;
      mem[13'h002] = 16'h0123; mem[13'h003] = 16'h0085;
      mem[13'h004] = 16'hC042; mem[13'h005] = 16'h0003;
      mem[13'h000] = 16'h0010; mem[13'h001] = 16'h000A;
      mem[13'h080] = 16'h0200; mem[13'h081] = 16'h0086;
      mem[13'h006] = 16'h4111; mem[13'h007] = 16'h0009;
      mem[13'h008] = 16'h0055; mem[13'h009] = 16'h000C;

      repeat (3) @(posedge clock);
      #1;
      chk_reset_state("rst");
      reset = 1'b0;
      @(posedge clock); #1;

      // Basic group: code 0123 / attr 0085 at col 1, line 5
      v_count = 9'd5;
      group("g1", 9'd0, 15'h091D);
      chk("g1_caddr", 32'(last_code_addr), 32'h002);
      chk("g1_color", 32'(color), 32'd5);
      chk("g1_prio",  32'(prio), 32'd1);
      chk("g1_flip",  32'(flip_x), 32'd0);
      chk("g1_blank", 32'(blank), 32'd0);
      chk("g1_pld",   32'(pixel_load_n), 32'd1);

      // Flip_y inverts the row, flip_x promoted on the load
      v_count = 9'd2;
      group("g2", 9'd8, 15'h0215);
      chk("g2_caddr", 32'(last_code_addr), 32'h004);
      chk("g2_flip",  32'(flip_x), 32'd1);
      chk("g2_color", 32'(color), 32'd3);
      chk("g2_prio",  32'(prio), 32'd0);

      // Column wrap: 0 + 1 + 63 -> 0
      v_count  = 9'd0;
      scroll_x = 9'd504;
      group("g3", 9'd0, 15'h0080);
      chk("g3_caddr", 32'(last_code_addr), 32'h000);
      chk("g3_col",   32'(last_code_addr[6:1]), 32'd0);
      chk("g3_color", 32'(color), 32'hA);

      // Line prefetch at h=504 fetches line v+1
      scroll_x = 9'd0;
      v_count  = 9'd10;
      group("g4", 9'd504, 15'h1003);
      chk("g4_caddr", 32'(last_code_addr), 32'h080);
      chk("g4_color", 32'(color), 32'd6);
      chk("g4_prio",  32'(prio), 32'd1);
      chk("g4_flip",  32'(flip_x), 32'd0);
      chk("g4_blank", 32'(blank), 32'd0);

      // Underrun: ack withheld across the load
      v_count   = 9'd0;
      ack_block = 1'b1;
      group("u1", 9'd16, 15'h1003);
      chk("u1_blank", 32'(blank), 32'd1);
      chk("u1_color", 32'(color), 32'd6);
      chk("u1_prio",  32'(prio), 32'd1);
      chk("u1_flip",  32'(flip_x), 32'd0);
      chk("u1_ucnt",  32'(underrun_cnt), 32'(URUN1));
      ack_block = 1'b0;
      group("u2", 9'd24, 15'h02A8);
      chk("u2_blank", 32'(blank), 32'd0);
      chk("u2_color", 32'(color), 32'hC);
      chk("u2_prio",  32'(prio), 32'd0);
      chk("u2_flip",  32'(flip_x), 32'd0);
      chk("u2_caddr", 32'(last_code_addr), 32'h008);
      chk("u2_aaddr", 32'(last_attr_addr), 32'h009);
      chk("u2_ucnt",  32'(underrun_cnt), 32'(URUN1));

      // Reset during an outstanding read, then a stray ack
      ack_block = 1'b1;
      pix(9'd32);
      chk("r_rd_busy", 32'(vram_if.vram_rd), 32'd1);
      chk("r_addr_busy", 32'(vram_if.vram_addr), 32'h00A);
      reset = 1'b1;
      repeat (2) @(posedge clock);
      #1;
      chk_reset_state("rin");
      reset = 1'b0;
      f_ack = 1'b1;
      @(posedge clock); #1;
      f_ack = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      chk_reset_state("rpost");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
